// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  // Default operand/result width.
  localparam int unsigned DEF_WIDTH = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor: d = a - b - bin, bout = borrow out.
// Built from two half-subtractors whose borrows are ORed together.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half-subtractor: a - b.
  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  // Second half-subtractor: (a - b) - bin.
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  // At most one stage can borrow, so an OR merges them.
  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first.
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : request, sampled only in IDLE or DONE
//   a, b       : operands, captured on an accepted start
//   busy       : high while bits are being processed
//   done       : one-cycle pulse; diff/borrow_out valid from this cycle
//   diff       : registered result a - b mod 2^WIDTH
//   borrow_out : final borrow, 1 iff a < b (unsigned)
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   res_sr;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               cell_d;
  logic               cell_bout;
  logic               load_c;
  logic               last_bit_c;

  // Single arithmetic cell, fed from the operand LSBs and the borrow flop.
  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  // Next-state logic; load_c marks an accepted start.
  always_comb begin
    state_d    = state_q;
    load_c     = 1'b0;
    last_bit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));
        if (last_bit_c) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == RUN);
      done    <= (state_d == DONE);
    end
  end

  // Operand/result shift datapath, bit counter and borrow flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_q   <= 1'b0;
      cnt_q      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load_c) begin
      a_sr     <= a;
      b_sr     <= b;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr   <= {cell_d, res_sr[WIDTH-1:1]};
      borrow_q <= cell_bout;
      cnt_q    <= cnt_q + CNT_W'(1);
      // Publish on the final bit; the last difference bit lands in the MSB.
      if (last_bit_c) begin
        diff       <= {cell_d, res_sr[WIDTH-1:1]};
        borrow_out <= cell_bout;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks   = 0;
  int failures = 0;

  // Expected {borrow_out, diff} per accepted start, oldest first.
  logic [W:0] sb_q[$];

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    logic [W:0] exp_v;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done at %0t", $time);
        end else begin
          exp_v = sb_q.pop_front();
          chk("sb_result", 32'({borrow_out, diff}), 32'(exp_v));
        end
      end
    end
  end

  // Wait for done (bounded); returns number of negedges waited, 0 on timeout.
  task automatic wait_done(output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done at %0t", $time);
      n = 0;
    end
  endtask

  // One single-cycle-start operation with latency, busy length and hold checks.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ed, input logic eb, input bit hold_chk);
    int n;
    int nb;
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    sb_q.push_back({eb, ed});
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    n     = 1;
    nb    = busy ? 1 : 0;
    if (!done) begin
      wait_done(n, nb);
      n  = (n == 0) ? 0 : n + 1;
      nb = nb + 1;
    end
    if (n != 0) begin
      chk("done_latency", 32'(n), 32'(9));
      chk("busy_cycles", 32'(nb), 32'(W));
      chk("busy_in_done", 32'(busy), 32'(0));
    end
    if (hold_chk) begin
      @(negedge clk);
      chk("done_single_pulse", 32'(done), 32'(0));
      repeat (3) @(negedge clk);
      chk("hold_diff", 32'(diff), 32'(ed));
      chk("hold_borrow", 32'(borrow_out), 32'(eb));
    end
  endtask

  initial begin
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];
    logic [W-1:0] bb_d[3];
    logic         bb_bo[3];
    int n;
    int nb;
    int ndone;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   rt;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", 32'({busy, done, borrow_out, diff}), 32'(0));
    end

    // Directed single operations.
    run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_op(8'h80, 8'h7F, 8'h01, 1'b0, 1'b1);

    // start re-asserted during RUN is ignored.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    sb_q.push_back({1'b0, 8'h0F});
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 8'h11; b = 8'h22; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(n, nb);
    if (n != 0) chk("ignored_start_latency", 32'(n + 4), 32'(9));
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start_no_second_done", 32'(ndone), 32'(0));
    chk("ignored_start_diff", 32'({borrow_out, diff}), 32'({1'b0, 8'h0F}));

    // start held high: back-to-back operations every W+1 cycles.
    bb_a[0] = 8'h5A; bb_b[0] = 8'h3C; bb_d[0] = 8'h1E; bb_bo[0] = 1'b0;
    bb_a[1] = 8'h00; bb_b[1] = 8'h01; bb_d[1] = 8'hFF; bb_bo[1] = 1'b1;
    bb_a[2] = 8'h80; bb_b[2] = 8'h7F; bb_d[2] = 8'h01; bb_bo[2] = 1'b0;
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; start = 1'b1;
    sb_q.push_back({bb_bo[0], bb_d[0]});
    for (int k = 0; k < 3; k++) begin
      wait_done(n, nb);
      if (n != 0) begin
        chk("b2b_interval", 32'(n), 32'(W + 1));
        chk("b2b_busy_cycles", 32'(nb), 32'(W));
      end
      if (k < 2) begin
        a = bb_a[k+1]; b = bb_b[k+1];
        sb_q.push_back({bb_bo[k+1], bb_d[k+1]});
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    chk("b2b_back_to_idle", 32'({busy, done}), 32'(0));

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    sb_q.push_back({1'b0, 8'h1E});
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", 32'(busy), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_diff", 32'({borrow_out, diff}), 32'(0));
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("reset_no_done", 32'(ndone), 32'(0));
    chk("reset_diff_held", 32'(diff), 32'(0));
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b1);

    // Random operand pairs against an unsigned reference.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rt = {1'b0, ra} - {1'b0, rb};
      run_op(ra, rb, rt[W-1:0], (ra < rb), 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
